// File: rtl/compress_issue_queue.sv
// rtl/compress_issue_queue.sv - 2-wide enqueue, 2-wide oldest-first issue, compressing issue queue
//
// Slot 0 always holds the oldest entry. Valid slots are contiguous from slot 0.
// Issued entries leave holes that are closed at the next edge by shifting
// younger entries down by 1 or 2 slots. New entries are appended behind the survivors.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           discard all entries (beats enqueue, issue and wakeup)
//   enq_valid[2]    enqueue request; 2'b10 acts as a single enqueue of the slot-1 instr
//   enq_data/tag    two payloads / source tags, [lo] = older
//   enq_rdy[2]      source already available at dispatch
//   enq_ready       room for two entries, based on registered count only
//   wk_valid/wk_tag two wakeup broadcasts
//   iss_valid[2]    port0 = oldest ready, port1 = second-oldest ready
//   iss_data        issued payloads, zero when the port has no entry
//   iss_ready[2]    functional-unit accept per port
//   count           number of valid entries
module compress_issue_queue #(
  parameter int DEPTH = 8,
  parameter int DW = 16,
  parameter int TAGW = 6,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        enq_valid,
  input  logic [2*DW-1:0]   enq_data,
  input  logic [2*TAGW-1:0] enq_tag,
  input  logic [1:0]        enq_rdy,
  output logic              enq_ready,
  input  logic [1:0]        wk_valid,
  input  logic [2*TAGW-1:0] wk_tag,
  output logic [1:0]        iss_valid,
  output logic [2*DW-1:0]   iss_data,
  input  logic [1:0]        iss_ready,
  output logic [CW-1:0]     count
);

  logic [DEPTH-1:0] valid_q, rdy_q;
  logic [TAGW-1:0]  tag_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [CW-1:0]    count_q;

  logic [DEPTH-1:0] valid_d, rdy_d;
  logic [TAGW-1:0]  tag_d [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [CW-1:0]    count_d;

  logic        found0, found1;
  int          p0, p1;
  logic [1:0]  fire;
  int          n_fire, fa, fb;
  logic        acc;
  int          n_enq;
  logic [DW-1:0]   e0_data, e1_data;
  logic [TAGW-1:0] e0_tag, e1_tag;
  logic            e0_rdy, e1_rdy;

  function automatic logic woken(input logic [TAGW-1:0] t);
    return (wk_valid[0] && (wk_tag[TAGW-1:0] == t)) ||
           (wk_valid[1] && (wk_tag[2*TAGW-1:TAGW] == t));
  endfunction

  assign count     = count_q;
  assign enq_ready = (DEPTH - int'(count_q)) >= 2;

  // Select the two oldest ready entries from registered state only, so an
  // entry woken this cycle cannot issue until the next one.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rdy_q[i]) begin
        if (!found0) begin
          found0 = 1'b1;
          p0 = i;
        end else if (!found1) begin
          found1 = 1'b1;
          p1 = i;
        end
      end
    end
  end

  always_comb begin
    iss_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (found0 && (p0 == i)) iss_data[DW-1:0] = data_q[i];
      if (found1 && (p1 == i)) iss_data[2*DW-1:DW] = data_q[i];
    end
  end

  assign iss_valid = {found1, found0};
  assign fire      = iss_valid & iss_ready;

  // fa/fb are the fired slot indices in ascending order. Unused ones sit
  // beyond the top slot so they never contribute to a shift.
  always_comb begin
    n_fire = 0;
    fa = DEPTH + 2;
    fb = DEPTH + 2;
    if (fire[0]) begin
      fa = p0;
      n_fire = 1;
      if (fire[1]) begin
        fb = p1;
        n_fire = 2;
      end
    end else if (fire[1]) begin
      fa = p1;
      n_fire = 1;
    end
  end

  // The first enqueued instr is the slot-1 instr when only enq_valid[1] is set.
  always_comb begin
    acc   = enq_ready && (enq_valid != 2'b00);
    n_enq = !acc ? 0 : ((enq_valid == 2'b11) ? 2 : 1);
    if (enq_valid == 2'b10) begin
      e0_data = enq_data[2*DW-1:DW];
      e0_tag  = enq_tag[2*TAGW-1:TAGW];
      e0_rdy  = enq_rdy[1] | woken(enq_tag[2*TAGW-1:TAGW]);
    end else begin
      e0_data = enq_data[DW-1:0];
      e0_tag  = enq_tag[TAGW-1:0];
      e0_rdy  = enq_rdy[0] | woken(enq_tag[TAGW-1:0]);
    end
    e1_data = enq_data[2*DW-1:DW];
    e1_tag  = enq_tag[2*TAGW-1:TAGW];
    e1_rdy  = enq_rdy[1] | woken(enq_tag[2*TAGW-1:TAGW]);
  end

  // Slot i pulls from slot i+sh, where sh counts fired slots at or below the
  // source. Wakeup is evaluated on the source slot before the move.
  always_comb begin
    int src;
    int base;
    src  = 0;
    base = int'(count_q) - n_fire;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = 1'b0;
      rdy_d[i]   = 1'b0;
      tag_d[i]   = '0;
      data_d[i]  = '0;
      src = i + ((i >= fa) ? 1 : 0) + ((i + 1 >= fb) ? 1 : 0);
      for (int j = 0; j < DEPTH; j++) begin
        if (j == src) begin
          valid_d[i] = valid_q[j];
          rdy_d[i]   = valid_q[j] & (rdy_q[j] | woken(tag_q[j]));
          tag_d[i]   = tag_q[j];
          data_d[i]  = data_q[j];
        end
      end
      if (!valid_d[i]) begin
        if ((n_enq >= 1) && (i == base)) begin
          valid_d[i] = 1'b1;
          rdy_d[i]   = e0_rdy;
          tag_d[i]   = e0_tag;
          data_d[i]  = e0_data;
        end else if ((n_enq == 2) && (i == base + 1)) begin
          valid_d[i] = 1'b1;
          rdy_d[i]   = e1_rdy;
          tag_d[i]   = e1_tag;
          data_d[i]  = e1_data;
        end
      end
    end
    count_d = count_q + CW'(n_enq) - CW'(n_fire);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      rdy_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      count_q <= count_d;
    end
  end

  // Payload and tag are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_compress_issue_queue.sv
// tb/tb_compress_issue_queue.sv - self-checking bench for compress_issue_queue
module tb_compress_issue_queue;
  localparam int DEPTH = 8;
  localparam int DW = 16;
  localparam int TAGW = 6;
  localparam int CW = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [1:0]        enq_valid, enq_rdy, wk_valid, iss_ready, iss_valid;
  logic [2*DW-1:0]   enq_data, iss_data;
  logic [2*TAGW-1:0] enq_tag, wk_tag;
  logic              enq_ready;
  logic [CW-1:0]     count;

  compress_issue_queue #(.DEPTH(DEPTH), .DW(DW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_tag(enq_tag), .enq_rdy(enq_rdy),
    .enq_ready(enq_ready), .wk_valid(wk_valid), .wk_tag(wk_tag),
    .iss_valid(iss_valid), .iss_data(iss_data), .iss_ready(iss_ready), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [DW-1:0]   d;
    logic [TAGW-1:0] t;
    logic            r;
  } ent_t;
  ent_t mq[$];
  ent_t nq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wk(input logic [TAGW-1:0] t);
    return (wk_valid[0] && wk_tag[TAGW-1:0] == t) || (wk_valid[1] && wk_tag[2*TAGW-1:TAGW] == t);
  endfunction

  // Oldest two ready entries in age order (indices into mq, -1 when absent).
  function automatic void pick(output int a, output int b);
    a = -1;
    b = -1;
    foreach (mq[k]) begin
      if (mq[k].r) begin
        if (a < 0) a = k;
        else if (b < 0) b = k;
      end
    end
  endfunction

  // Reference model: the queue is an age-ordered list; issue removes entries,
  // wakeup marks survivors ready, enqueue appends.
  always @(posedge clk) begin
    int a, b;
    bit f0, f1;
    if (rst || flush) begin
      mq.delete();
    end else begin
      pick(a, b);
      f0 = (a >= 0) && iss_ready[0];
      f1 = (b >= 0) && iss_ready[1];
      nq.delete();
      foreach (mq[k]) begin
        ent_t e;
        e = mq[k];
        if (!((f0 && k == a) || (f1 && k == b))) begin
          if (wk(e.t)) e.r = 1'b1;
          nq.push_back(e);
        end
      end
      if (mq.size() <= DEPTH - 2) begin
        if (enq_valid[0]) nq.push_back('{enq_data[DW-1:0], enq_tag[TAGW-1:0],
                                         enq_rdy[0] | wk(enq_tag[TAGW-1:0])});
        if (enq_valid[1]) nq.push_back('{enq_data[2*DW-1:DW], enq_tag[2*TAGW-1:TAGW],
                                         enq_rdy[1] | wk(enq_tag[2*TAGW-1:TAGW])});
      end
      mq = nq;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int a, b;
    logic [2*DW-1:0] ed;
    if (chk_en) begin
      pick(a, b);
      ed = '0;
      if (a >= 0) ed[DW-1:0] = mq[a].d;
      if (b >= 0) ed[2*DW-1:DW] = mq[b].d;
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_enq_ready", 64'(enq_ready), 64'(mq.size() <= DEPTH - 2));
      chk("m_iss_valid", 64'(iss_valid), 64'({b >= 0, a >= 0}));
      chk("m_iss_data", 64'(iss_data), 64'(ed));
    end
  end

  task automatic idle();
    flush = 0; enq_valid = 0; enq_data = 0; enq_tag = 0; enq_rdy = 0;
    wk_valid = 0; wk_tag = 0; iss_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq2(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [TAGW-1:0] t0, input logic [TAGW-1:0] t1,
                      input logic [1:0] v, input logic [1:0] r);
    enq_valid = v; enq_data = {d1, d0}; enq_tag = {t1, t0}; enq_rdy = r;
    tick();
    enq_valid = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("rst_count", 64'(count), 0);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_iss_data", 64'(iss_data), 0);
    chk("rst_enq_ready", 64'(enq_ready), 1);

    // Dual enqueue, both ready, issue one cycle later in age order.
    enq2(16'h1111, 16'h2222, 6'd1, 6'd2, 2'b11, 2'b11);
    chk("t1_count", 64'(count), 2);
    chk("t1_iss_valid", 64'(iss_valid), 2'b11);
    chk("t1_iss_data", 64'(iss_data), 64'h2222_1111);
    do_flush();

    // Full queue rejects further dispatch.
    for (int k = 0; k < 4; k++) enq2(16'(k * 2), 16'(k * 2 + 1), 6'd20, 6'd21, 2'b11, 2'b00);
    chk("t2_count_full", 64'(count), 8);
    chk("t2_enq_ready", 64'(enq_ready), 0);
    enq2(16'hdead, 16'hbeef, 6'd22, 6'd23, 2'b11, 2'b11);
    chk("t2_count_hold", 64'(count), 8);
    do_flush();

    // A..F with only B and E ready; both fire and the rest compress in order.
    enq2(16'h00a0, 16'h00b0, 6'd10, 6'd11, 2'b11, 2'b10);
    enq2(16'h00c0, 16'h00d0, 6'd12, 6'd13, 2'b11, 2'b00);
    enq2(16'h00e0, 16'h00f0, 6'd14, 6'd15, 2'b11, 2'b01);
    chk("t3_sel", 64'(iss_data), 64'h00e0_00b0);
    iss_ready = 2'b11;
    tick();
    iss_ready = 2'b00;
    chk("t3_count", 64'(count), 4);
    wk_valid = 2'b11; wk_tag = {6'd12, 6'd10};
    tick();
    chk("t3_ac", 64'(iss_data), 64'h00c0_00a0);
    wk_tag = {6'd15, 6'd13}; iss_ready = 2'b11;
    tick();
    wk_valid = 0; iss_ready = 0;
    chk("t3_df", 64'(iss_data), 64'h00f0_00d0);
    chk("t3_count2", 64'(count), 2);
    do_flush();

    // Wakeup of tag 5 hits slots 2, 4 and a same-cycle enqueue.
    enq2(16'h0040, 16'h0041, 6'd1, 6'd2, 2'b11, 2'b00);
    enq2(16'h0042, 16'h0043, 6'd5, 6'd3, 2'b11, 2'b00);
    enq2(16'h0044, 16'h0000, 6'd5, 6'd0, 2'b01, 2'b00);
    chk("t4_not_ready", 64'(iss_valid), 0);
    wk_valid = 2'b01; wk_tag = {6'd0, 6'd5};
    enq2(16'h004f, 16'h0000, 6'd5, 6'd0, 2'b01, 2'b00);
    wk_valid = 0;
    chk("t4_count", 64'(count), 6);
    chk("t4_oldest", 64'(iss_data), 64'h0044_0042);
    iss_ready = 2'b11;
    tick();
    iss_ready = 0;
    chk("t4_third", 64'(iss_data), 64'h0000_004f);
    chk("t4_count2", 64'(count), 4);

    // Two fire plus two enqueue: new entries land behind survivors.
    wk_valid = 2'b11; wk_tag = {6'd2, 6'd1};
    tick();
    wk_valid = 0;
    iss_ready = 2'b11;
    enq2(16'h0050, 16'h0051, 6'd30, 6'd31, 2'b11, 2'b11);
    iss_ready = 0;
    chk("t5_count", 64'(count), 4);
    chk("t5_data", 64'(iss_data), 64'h0050_004f);

    // Only port1 accepts: the oldest ready stays at the front.
    iss_ready = 2'b10;
    tick();
    iss_ready = 0;
    chk("t6_count", 64'(count), 3);
    chk("t6_data", 64'(iss_data), 64'h0051_004f);

    // Single enqueue through the slot-1 lane.
    enq2(16'h0000, 16'h0077, 6'd0, 6'd40, 2'b10, 2'b10);
    chk("t6_lane1", 64'(count), 4);

    // Flush beats a same-cycle enqueue.
    enq_valid = 2'b11; enq_rdy = 2'b11; flush = 1;
    tick();
    idle();
    chk("t6_flush_count", 64'(count), 0);
    chk("t6_flush_iss", 64'(iss_valid), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      enq_valid = 2'($urandom_range(0, 3));
      enq_data  = $urandom;
      enq_tag   = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      enq_rdy   = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
      wk_valid  = 2'($urandom_range(0, 3));
      wk_tag    = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      iss_ready = (n % 500 < 250) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1) * 3);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/compress_issue_queue.md
Name: compress_issue_queue

Overview:
- Compressing issue queue: 2-wide in-order enqueue, 2-wide oldest-first issue.
- Holes left by issued entries are closed every cycle by shifting younger entries down by 1 or 2 slots. Slot 0 is always the oldest entry.
- Sits between dispatch/rename (upstream) and two functional-unit ports (downstream).
- Owns per-slot valid/ready state, tag wakeup, select and shift control (per-slot shift-by-0/1/2 selection, enqueue write enable, enqueue source select).

Parameters:
- DEPTH, 8, number of slots (≥4, power of two not required).
- DW, 16, payload width per entry.
- TAGW, 6, physical source tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries
- enq_valid  in  2  bit0 = first (older) instr, bit1 = second; 2'b10 treated as 2'b01 with slot-1 data
- enq_data  in  2*DW  [DW-1:0] older, [2DW-1:DW] younger
- enq_tag  in  2*TAGW  source tag per enqueued instr
- enq_rdy  in  2  source already available at dispatch
- enq_ready  out  1  queue can accept two entries this cycle
- wk_valid  in  2  wakeup broadcast valid
- wk_tag  in  2*TAGW  wakeup tags
- iss_valid  out  2  port0 = oldest ready, port1 = second-oldest ready
- iss_data  out  2*DW  issued payloads
- iss_ready  in  2  FU accepts
- count  out  $clog2(DEPTH+1)  valid entries

Behaviour:
- Reset or flush (registered, next edge): all valid = 0, all ready = 0, count = 0. Outputs after reset: iss_valid = 0, iss_data = 0, enq_ready = 1. Flush beats same-cycle enqueue, issue and wakeup.
- Slot state: valid, rdy, tag[TAGW], data[DW]. Valid slots are always contiguous from slot 0.
- enq_ready = (DEPTH − count ≥ 2).
  - Combinational from the registered count only; same-cycle issues are not credited.
  - Dispatch is all-or-nothing.
  - enq_valid while enq_ready = 0 is ignored; no entry is written and count is unchanged.
- Wakeup:
  - A valid slot whose tag equals any valid wk_tag sets rdy at the next edge.
  - An enqueuing instr whose tag matches a same-cycle wakeup enters with rdy = 1.
  - Otherwise it enters with enq_rdy.
- Select (combinational from registered state):
  - p0 = lowest-index slot with valid & rdy.
  - p1 = next such slot above p0.
  - iss_valid[k] = slot found. iss_data[k] = that slot's data, else 0.
- Fire: fire[k] = iss_valid[k] & iss_ready[k]. Ports fire independently; port1 may fire when port0 does not.
- Compression, per slot i, at the next edge:
  - Slot i takes the contents of slot i+s, where s = number of fired slots with index ≤ i+s (0, 1 or 2).
  - Realised as a per-slot shift amount: 0, up-by-1 or up-by-2 relative to the source slot.
  - Wakeup matches apply to moved entries at the same edge; rdy is computed on the source slot, then moved.
  - Top slots vacated by the shift become invalid unless filled by enqueue.
- Enqueue placement:
  - Base slot b = count − popcount(fire).
  - Older instr → slot b; younger → slot b+1.
  - If only one enq is valid, the instr given by the enq_valid encoding above goes to slot b.
- count_next = count + n_enq − n_fire. This never exceeds DEPTH and never goes below 0.
- Latency:
  - Enqueue to earliest issue: 1 cycle (entry must be rdy when written).
  - Wakeup to issue of a waiting entry: 1 cycle.
- Issuing an entry in the same cycle it is woken is not allowed.
- Ordering invariant: relative age order of surviving entries is preserved across any combination of enqueue and 0/1/2 issues.

Test Plan:
- Reset then enq_valid = 2'b11, enq_rdy = 2'b11, iss_ready = 0 → next cycle count = 2 and iss_valid = 2'b11. iss_data port0 = older payload, port1 = younger payload.
- Fill 8 entries with rdy = 0 → count = 8, enq_ready = 0. Present enq_valid = 2'b11 → ignored, count stays 8.
- 6 entries A..F, rdy only on B and E, iss_ready = 2'b11 → B and E fire. Next cycle slots hold A, C, D, F, count = 4, no other entry moved out of order.
- Wakeup tag 5 while slots 2 and 4 hold tag 5, plus a same-cycle enqueue with tag 5 and enq_rdy = 0 → all three rdy next cycle. Oldest two issue first.
- Simultaneous: count = 4, 2 fire, 2 enqueue → count = 4. New entries land at slots 2 and 3 behind the survivors.
- iss_ready = 2'b10 with two ready entries → only the second-oldest leaves; the oldest stays at slot 0. Flush asserted mid-operation with enqueue → count = 0, iss_valid = 0 next cycle.
